// File: rtl/gnss_buf_pkg.sv
// Constants and state encoding for the GNSS capture buffer.
// The capture writer uses this package as well.
package gnss_buf_pkg;

  localparam int WORD_W     = 36;
  localparam int SPW        = 18;
  localparam int DEPTH      = 512;
  localparam int WIDX_W     = 9;
  localparam int ADDR_SHIFT = 5;
  localparam int ADDR_W     = WIDX_W + ADDR_SHIFT;
  localparam int CNT_W      = $clog2(SPW);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/iq_buf_reader_word_unpacker.sv
// Serializes packed I/Q words into one sample per handshake, with a
// one-word prefetch slot so word boundaries cost no bubble.
module word_unpacker
  import gnss_buf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic [WORD_W-1:0] word_in_i,
  input  logic              word_we_i,
  output logic              need_word_o,
  output logic              drained_o,
  input  logic              s_ready_i,
  output logic              s_valid_o,
  output logic              s_i_o,
  output logic              s_q_o
);

  logic [SPW-1:0]    cur_ih_q, cur_ih_d;
  logic [SPW-1:0]    cur_qh_q, cur_qh_d;
  logic              cur_v_q, cur_v_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] nxt_q, nxt_d;
  logic              nxt_v_q, nxt_v_d;
  logic              hs;
  logic              cur_end;

  assign hs      = cur_v_q & s_ready_i;
  assign cur_end = hs && (cnt_q == CNT_W'(SPW - 1));

  always_comb begin
    cur_ih_d = cur_ih_q;
    cur_qh_d = cur_qh_q;
    cur_v_d  = cur_v_q;
    cnt_d    = cnt_q;
    nxt_d    = nxt_q;
    nxt_v_d  = nxt_v_q;
    // Shifting out toward bit 0 leaves the halves all-zero once drained.
    if (hs) begin
      cur_ih_d = cur_ih_q >> 1;
      cur_qh_d = cur_qh_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
    end
    if (cur_end) begin
      cnt_d   = '0;
      cur_v_d = nxt_v_q;
      if (nxt_v_q) begin
        cur_ih_d = nxt_q[SPW-1:0];
        cur_qh_d = nxt_q[WORD_W-1:SPW];
        nxt_v_d  = 1'b0;
      end
    end
    if (word_we_i) begin
      if (!cur_v_d) begin
        cur_ih_d = word_in_i[SPW-1:0];
        cur_qh_d = word_in_i[WORD_W-1:SPW];
        cur_v_d  = 1'b1;
        cnt_d    = '0;
      end else begin
        nxt_d   = word_in_i;
        nxt_v_d = 1'b1;
      end
    end
    if (flush_i) begin
      cur_ih_d = '0;
      cur_qh_d = '0;
      cur_v_d  = 1'b0;
      cnt_d    = '0;
      nxt_d    = '0;
      nxt_v_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_ih_q <= '0;
      cur_qh_q <= '0;
      cur_v_q  <= 1'b0;
      cnt_q    <= '0;
      nxt_q    <= '0;
      nxt_v_q  <= 1'b0;
    end else begin
      cur_ih_q <= cur_ih_d;
      cur_qh_q <= cur_qh_d;
      cur_v_q  <= cur_v_d;
      cnt_q    <= cnt_d;
      nxt_q    <= nxt_d;
      nxt_v_q  <= nxt_v_d;
    end
  end

  assign need_word_o = !nxt_v_q;
  assign drained_o   = cur_end && !nxt_v_q;
  assign s_valid_o   = cur_v_q;
  assign s_i_o       = cur_ih_q[0];
  assign s_q_o       = cur_qh_q[0];

endmodule

// File: rtl/iq_buf_reader.sv
// Replays a captured I/Q buffer region as a valid/ready sample stream,
// with circular addressing and a repeat count for per-Doppler-bin reuse.
module iq_buf_reader
  import gnss_buf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WIDX_W-1:0] base_word,
  input  logic [WIDX_W:0]   num_words,
  input  logic [7:0]        num_passes,
  output logic              busy,
  output logic              done,
  output logic              mem_ce,
  output logic [ADDR_W-1:0] mem_ad,
  input  logic [WORD_W-1:0] mem_do,
  output logic              s_valid,
  input  logic              s_ready,
  output logic              s_i,
  output logic              s_q
);

  state_t            state_q;
  logic              busy_q, done_q, mem_ce_q, pend_q;
  logic [ADDR_W-1:0] mem_ad_q;
  logic [WIDX_W-1:0] base_q, idx_q;
  logic [WIDX_W:0]   nw_q, wcnt_q;
  logic [17:0]       left_q;
  logic [7:0]        passes_eff;
  logic [17:0]       total_reads;
  logic              need_word, drained, issue, finish;

  assign passes_eff  = (num_passes == 8'd0) ? 8'd1 : num_passes;
  assign total_reads = 18'(num_words) * 18'(passes_eff);

  // A read may only go out once the previous one has landed in the unpacker.
  assign issue  = (state_q == RUN) && need_word && !mem_ce_q && !pend_q && (left_q != '0);
  assign finish = (state_q == RUN) && drained && !mem_ce_q && !pend_q && (left_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mem_ce_q <= 1'b0;
      pend_q   <= 1'b0;
      mem_ad_q <= '0;
      base_q   <= '0;
      idx_q    <= '0;
      nw_q     <= '0;
      wcnt_q   <= '0;
      left_q   <= '0;
    end else if (abort) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mem_ce_q <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      pend_q   <= mem_ce_q;
      mem_ce_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            base_q <= base_word;
            nw_q   <= num_words;
            busy_q <= 1'b1;
            if (num_words == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              // First read goes out straight from the start edge.
              state_q  <= RUN;
              mem_ce_q <= 1'b1;
              mem_ad_q <= {base_word, {ADDR_SHIFT{1'b0}}};
              left_q   <= total_reads - 18'd1;
              if (num_words == (WIDX_W+1)'(1)) begin
                idx_q  <= base_word;
                wcnt_q <= num_words;
              end else begin
                idx_q  <= base_word + WIDX_W'(1);
                wcnt_q <= num_words - (WIDX_W+1)'(1);
              end
            end
          end
        end
        RUN: begin
          if (issue) begin
            mem_ce_q <= 1'b1;
            mem_ad_q <= {idx_q, {ADDR_SHIFT{1'b0}}};
            left_q   <= left_q - 18'd1;
            if (wcnt_q == (WIDX_W+1)'(1)) begin
              idx_q  <= base_q;
              wcnt_q <= nw_q;
            end else begin
              idx_q  <= idx_q + WIDX_W'(1);
              wcnt_q <= wcnt_q - (WIDX_W+1)'(1);
            end
          end
          if (finish) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  word_unpacker u_unpacker (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (abort),
    .word_in_i   (mem_do),
    .word_we_i   (pend_q),
    .need_word_o (need_word),
    .drained_o   (drained),
    .s_ready_i   (s_ready),
    .s_valid_o   (s_valid),
    .s_i_o       (s_i),
    .s_q_o       (s_q)
  );

  assign busy   = busy_q;
  assign done   = done_q;
  assign mem_ce = mem_ce_q;
  assign mem_ad = mem_ad_q;

endmodule

// File: tb/tb_iq_buf_reader.sv
// Scoreboard bench for iq_buf_reader: a BSRAM model, a queue-based
// reference of expected samples/reads, and a negedge monitor.
module tb_iq_buf_reader;
  import gnss_buf_pkg::*;

  logic              clk = 1'b0;
  logic              rst, start, abort;
  logic [WIDX_W-1:0] base_word;
  logic [WIDX_W:0]   num_words;
  logic [7:0]        num_passes;
  logic              busy, done, mem_ce;
  logic [ADDR_W-1:0] mem_ad;
  logic [WORD_W-1:0] mem_do;
  logic              s_valid, s_ready, s_i, s_q;

  always #5 clk = ~clk;

  iq_buf_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .base_word  (base_word),
    .num_words  (num_words),
    .num_passes (num_passes),
    .busy       (busy),
    .done       (done),
    .mem_ce     (mem_ce),
    .mem_ad     (mem_ad),
    .mem_do     (mem_do),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_i        (s_i),
    .s_q        (s_q)
  );

  logic [WORD_W-1:0] mem [0:DEPTH-1];

  always @(posedge clk) begin
    if (mem_ce) mem_do <= mem[mem_ad[ADDR_W-1:ADDR_SHIFT]];
  end

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [1:0] exp_q[$];
  int         rd_q[$];
  int         hs_cnt   = 0;
  int         done_cnt = 0;
  bit         rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Reference: the pass/word/sample order follows directly from the
  // replay rules (circular index, k ascending, passes repeat the region).
  task automatic push_model(input int b, input int nw, input int np);
    int passes;
    int idx;
    passes = (np == 0) ? 1 : np;
    for (int p = 0; p < passes; p++) begin
      for (int w = 0; w < nw; w++) begin
        idx = (b + w) % DEPTH;
        rd_q.push_back(idx);
        for (int k = 0; k < SPW; k++) exp_q.push_back({mem[idx][k], mem[idx][SPW+k]});
      end
    end
  endtask

  initial begin
    s_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      s_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: samples, reads, stall stability and done pulses.
  logic       prev_stall = 1'b0;
  logic       prev_ce    = 1'b0;
  logic [1:0] prev_iq    = 2'b00;
  logic [1:0] e;
  initial begin
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (prev_stall) begin
        chk("stall_valid", s_valid, 1);
        chk("stall_data", {s_i, s_q}, prev_iq);
      end
      if (s_valid && s_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sample: actual i=%0d q=%0d, required no sample", s_i, s_q);
        end else begin
          e = exp_q.pop_front();
          chk("sample", {s_i, s_q}, e);
        end
      end
      if (mem_ce) begin
        chk("one_outstanding", prev_ce, 0);
        if (rd_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL read_addr: actual 0x%0h, required no read", mem_ad);
        end else begin
          chk("read_addr", mem_ad, 64'(rd_q.pop_front() << ADDR_SHIFT));
        end
      end
      prev_ce    = mem_ce;
      prev_stall = (rst || abort) ? 1'b0 : (s_valid && !s_ready);
      prev_iq    = {s_i, s_q};
    end
  end

  // exp_lat < 0 skips the latency check; inject pulses a bogus start mid-run.
  task automatic run_job(input int b, input int nw, input int np, input bit rnd,
                         input int exp_lat, input bit inject);
    int  k;
    bit  got;
    rand_rdy = rnd;
    push_model(b, nw, np);
    base_word  = WIDX_W'(b);
    num_words  = (WIDX_W+1)'(nw);
    num_passes = 8'(np);
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    k   = 0;
    got = 1'b0;
    while (!got && k < 5000) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        chk("busy_after_start", busy, 1);
        chk("mem_ce_after_start", mem_ce, (nw != 0));
      end
      if (done) got = 1'b1;
      if (inject && k == 20) begin
        base_word  = 9'd200;
        num_words  = 10'd7;
        num_passes = 8'd2;
        start      = 1'b1;
      end
      if (inject && k == 21) start = 1'b0;
    end
    chk("done_seen", got, 1);
    if (exp_lat >= 0) chk("done_latency", k, exp_lat);
    @(negedge clk);
    chk("idle_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
    chk("samples_left", exp_q.size(), 0);
    chk("reads_left", rd_q.size(), 0);
    $display("job base=%0d words=%0d passes=%0d rnd_ready=%0d cycles=%0d", b, nw, np, rnd, k);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_samples(input int n, input string name);
    int h0;
    int c;
    h0 = hs_cnt;
    c  = 0;
    while (hs_cnt - h0 < n && c < 2000) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk(name, (hs_cnt - h0 >= n), 1);
  endtask

  int dc;
  int nw_r, np_r, b_r;

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    base_word  = '0;
    num_words  = '0;
    num_passes = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = {4'($urandom), 32'($urandom)};
    mem[0] = 36'h0_0003_FFFF;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_outputs", {busy, done, s_valid, s_i, s_q, mem_ce, mem_ad}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_job(0, 1, 1, 1'b0, 3 + 18, 1'b0);              // basic
    run_job(510, 4, 1, 1'b0, 3 + 72, 1'b0);            // wrap
    run_job(int'($urandom_range(0, 511)), 3, 1, 1'b1, -1, 1'b0);  // backpressure
    run_job(37, 2, 3, 1'b0, 3 + 108, 1'b0);            // repeat
    run_job(80, 2, 0, 1'b0, 3 + 36, 1'b0);             // zero passes as one
    run_job(5, 0, 1, 1'b0, 1, 1'b0);                   // empty run
    run_job(100, 4, 1, 1'b0, 3 + 72, 1'b1);            // start while busy

    // abort mid-word
    rand_rdy = 1'b0;
    push_model(300, 3, 1);
    base_word  = 9'd300;
    num_words  = 10'd3;
    num_passes = 8'd1;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_samples(10, "abort_reached");
    dc    = done_cnt;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    exp_q.delete();
    rd_q.delete();
    @(negedge clk);
    chk("abort_s_valid", s_valid, 0);
    chk("abort_mem_ce", mem_ce, 0);
    chk("abort_busy", busy, 0);
    repeat (30) @(negedge clk);
    chk("abort_no_done", done_cnt, dc);
    chk("abort_stays_idle", {busy, s_valid}, 0);
    $display("abort after 10 samples of base=300 words=3");
    @(posedge clk);
    #1;
    run_job(7, 2, 1, 1'b0, 3 + 36, 1'b0);

    // reset mid-run
    push_model(450, 3, 1);
    base_word  = 9'd450;
    num_words  = 10'd3;
    num_passes = 8'd1;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_samples(25, "reset_reached");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    rd_q.delete();
    @(negedge clk);
    chk("midrun_reset_outputs", {busy, done, s_valid, s_i, s_q, mem_ce, mem_ad}, 0);
    $display("reset after 25 samples of base=450 words=3");
    @(posedge clk);
    #1;
    run_job(450, 3, 1, 1'b0, 3 + 54, 1'b0);

    for (int j = 0; j < 6; j++) begin
      b_r  = int'($urandom_range(0, 511));
      nw_r = int'($urandom_range(1, 6));
      np_r = int'($urandom_range(0, 3));
      if (j % 2 == 0)
        run_job(b_r, nw_r, np_r, 1'b1, -1, 1'b0);
      else
        run_job(b_r, nw_r, np_r, 1'b0, 3 + 18 * nw_r * ((np_r == 0) ? 1 : np_r), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual time limit reached, required run to finish");
    $fatal(1);
  end

endmodule
